// File: rtl/param_cnn_classifier_pkg.sv
// Shared definitions for the parametrised CNN classifier: FSM state
// encoding and the saturating accumulator add used by the FC stage.
package param_cnn_classifier_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FC   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Adds two wide signed values and clamps the result to a signed w-bit
    // range. Operands must already fit comfortably inside 64 bits (w <= 62).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/param_cnn_classifier_window_mac.sv
// Combinational KxK dot product of an unsigned pixel window with a signed
// kernel, followed by ReLU. Pixels are zero-extended by one bit so the
// multiply is fully signed.
module param_cnn_classifier_window_mac #(
    parameter int K     = 5,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int ACC_W = 32
) (
    input  logic [K*K*WW-1:0]        i_kernel,
    input  logic [K*K*DW-1:0]        i_win,
    output logic signed [ACC_W-1:0]  o_relu
);

    localparam int PW = DW + WW + 1;

    logic signed [PW-1:0]    w_prod [K*K];
    logic signed [ACC_W-1:0] w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < K*K; gi++) begin : g_tap
            assign w_prod[gi] = PW'($signed({1'b0, i_win[gi*DW +: DW]}))
                              * PW'($signed(i_kernel[gi*WW +: WW]));
        end
    endgenerate

    // Sum all tap products, sign-extended to the accumulator width.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < K*K; i++) begin
            w_sum = w_sum + ACC_W'(w_prod[i]);
        end
    end

    assign o_relu = w_sum[ACC_W-1] ? '0 : w_sum;

endmodule

// File: rtl/param_cnn_classifier.sv
// One conv layer + ReLU + one FC layer + argmax. Windows arrive in raster
// order and fill an internal feature RAM; the FC stage then streams weights
// from an external 1-cycle-latency ROM, one MAC per cycle, with one drain
// cycle per class so each class score completes on a fixed cadence.
module param_cnn_classifier
    import param_cnn_classifier_pkg::*;
#(
    parameter int IMG    = 28,
    parameter int K      = 5,
    parameter int NCLASS = 10,
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int ACC_W  = 32
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic                                            i_start,
    input  logic [K*K*WW-1:0]                               i_kernel,
    input  logic                                            i_in_valid,
    output logic                                            o_in_ready,
    input  logic [K*K*DW-1:0]                               i_in_win,
    output logic [$clog2(NCLASS*(IMG-K+1)*(IMG-K+1))-1:0]   o_fc_addr,
    output logic                                            o_fc_en,
    input  logic [WW-1:0]                                   i_fc_wdata,
    output logic                                            o_busy,
    output logic                                            o_done,
    output logic [$clog2(NCLASS)-1:0]                       o_out,
    output logic [ACC_W-1:0]                                o_score
);

    localparam int FMAP = IMG - K + 1;
    localparam int N2   = FMAP * FMAP;
    localparam int AW   = $clog2(NCLASS * N2);
    localparam int CW   = $clog2(NCLASS);
    localparam int IW   = $clog2(N2 + 1);
    localparam int FW   = $clog2(N2);
    localparam int RW   = $clog2(FMAP);

    localparam logic [RW-1:0] POS_LAST  = RW'(FMAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N2 - 1);
    localparam logic [IW-1:0] IDX_DRAIN = IW'(N2);
    localparam logic [CW-1:0] CLS_LAST  = CW'(NCLASS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [RW-1:0]           r_row;
    logic [RW-1:0]           r_col;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cls;
    logic [AW-1:0]           r_fc_addr;
    logic                    w_fc_en;
    logic                    w_accept;
    logic [FW-1:0]           w_waddr;
    logic signed [ACC_W-1:0] w_feat;

    logic signed [ACC_W-1:0] r_feat_mem [N2];
    logic signed [ACC_W-1:0] r_feat;

    logic                    r_mac_vld;
    logic                    r_mac_first;
    logic                    r_mac_last;
    logic [CW-1:0]           r_mac_cls;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_best_score;
    logic [CW-1:0]           r_best_cls;
    logic [CW-1:0]           r_out;
    logic signed [ACC_W-1:0] r_score;

    logic signed [63:0]      w_wext;
    logic signed [63:0]      w_fext;
    logic signed [63:0]      w_base;
    logic signed [ACC_W-1:0] w_score;
    logic                    w_take;

    param_cnn_classifier_window_mac #(
        .K     (K),
        .DW    (DW),
        .WW    (WW),
        .ACC_W (ACC_W)
    ) u_window_mac (
        .i_kernel (i_kernel),
        .i_win    (i_in_win),
        .o_relu   (w_feat)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        w_fc_en      = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                o_in_ready = 1'b1;
                if (i_in_valid && r_row == POS_LAST && r_col == POS_LAST) begin
                    w_state_next = S_FC;
                end
            end
            S_FC: begin
                w_fc_en = (r_idx != IDX_DRAIN);
                if (r_idx == IDX_DRAIN && r_cls == CLS_LAST) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_fc_en   = w_fc_en;
    assign o_fc_addr = r_fc_addr;
    assign w_accept  = o_in_ready && i_in_valid;
    assign w_waddr   = FW'(r_row) * FW'(FMAP) + FW'(r_col);

    // Window raster counters and FC fetch counters; all cleared on START.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_idx     <= '0;
            r_cls     <= '0;
            r_fc_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row     <= '0;
                        r_col     <= '0;
                        r_idx     <= '0;
                        r_cls     <= '0;
                        r_fc_addr <= '0;
                    end
                end
                S_CONV: begin
                    if (w_accept) begin
                        if (r_col == POS_LAST) begin
                            r_col <= '0;
                            r_row <= (r_row == POS_LAST) ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_FC: begin
                    if (r_idx == IDX_DRAIN) begin
                        r_idx <= '0;
                        r_cls <= r_cls + 1'b1;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        r_fc_addr <= r_fc_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Feature RAM: written by the conv stage, registered read aligned with ROM data.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_feat_mem[w_waddr] <= w_feat;
        end
        if (w_fc_en) begin
            r_feat <= r_feat_mem[r_idx[FW-1:0]];
        end
    end

    // Pipeline tags travelling one cycle behind each weight fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mac_vld   <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
            r_mac_cls   <= '0;
        end else begin
            r_mac_vld   <= w_fc_en;
            r_mac_first <= w_fc_en && (r_idx == '0);
            r_mac_last  <= w_fc_en && (r_idx == IDX_LAST);
            r_mac_cls   <= r_cls;
        end
    end

    assign w_wext  = r_mac_vld ? 64'($signed(i_fc_wdata)) : 64'sd0;
    assign w_fext  = 64'(r_feat);
    assign w_base  = r_mac_first ? 64'sd0 : 64'(r_acc);
    assign w_score = ACC_W'(sat_add(w_base, w_wext * w_fext, ACC_W));
    assign w_take  = (r_mac_cls == '0) || (w_score > r_best_score);

    // Saturating MAC, running argmax, and result latch on the final class.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_cls   <= '0;
            r_out        <= '0;
            r_score      <= '0;
        end else if (r_mac_vld) begin
            r_acc <= w_score;
            if (r_mac_last) begin
                if (w_take) begin
                    r_best_score <= w_score;
                    r_best_cls   <= r_mac_cls;
                end
                if (r_mac_cls == CLS_LAST) begin
                    r_out   <= w_take ? r_mac_cls : r_best_cls;
                    r_score <= w_take ? w_score : r_best_score;
                end
            end
        end
    end

    assign o_out   = r_out;
    assign o_score = r_score;

endmodule

// File: tb/tb_param_cnn_classifier.sv
// Scoreboard bench for param_cnn_classifier: the driver pushes the expected
// class/score per image, a monitor pops and compares on every DONE pulse.
module tb_param_cnn_classifier;

    localparam int IMG    = 28;
    localparam int K      = 5;
    localparam int NCLASS = 10;
    localparam int FMAP   = IMG - K + 1;
    localparam int N2     = FMAP * FMAP;
    localparam int NROM   = NCLASS * N2;
    localparam int LAT    = NCLASS * (N2 + 1) + 1;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk;
    logic          rst;
    logic          start;
    logic [K*K*8-1:0] kernel;
    logic          in_valid;
    logic          in_ready;
    logic [K*K*8-1:0] in_win;
    logic [12:0]   fc_addr;
    logic          fc_en;
    logic [7:0]    fc_wdata;
    logic          busy;
    logic          done;
    logic [3:0]    out_cls;
    logic [31:0]   score;

    param_cnn_classifier dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_kernel   (kernel),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_win   (in_win),
        .o_fc_addr  (fc_addr),
        .o_fc_en    (fc_en),
        .i_fc_wdata (fc_wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_out      (out_cls),
        .o_score    (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] rom [NROM];
    logic [7:0]        img [IMG][IMG];
    int                ktap [K*K];

    typedef struct {
        string  name;
        int     cls;
        longint score;
    } exp_t;
    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;
    longint cyc = 0;
    longint last_acc = 0;
    int exp_addr = 0;
    int addr_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // ROM model: data one cycle after the enable.
    always @(posedge clk) begin
        if (fc_en) fc_wdata <= rom[fc_addr];
    end

    // Cycle counter and last accepted window.
    always @(posedge clk) begin
        if (in_valid && in_ready) last_acc <= cyc;
        cyc <= cyc + 1;
    end

    // Fetch address contiguity tracking.
    always @(negedge clk) begin
        if (!rst && fc_en) begin
            if (int'(fc_addr) != exp_addr) addr_bad++;
            exp_addr++;
        end
    end

    // Monitor: pop and compare on every DONE.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got DONE required none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_out"}, longint'(out_cls), e.cls);
                check({e.name, "_score"}, longint'($signed(score)), e.score);
                check({e.name, "_latency"}, cyc - last_acc, LAT);
                check({e.name, "_addr_seq_errors"}, addr_bad, 0);
                check({e.name, "_fetch_count"}, exp_addr, NROM);
                $display("txn %s: out=%0d score=%0d expected out=%0d score=%0d",
                         e.name, out_cls, $signed(score), e.cls, e.score);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_fc_en"}, fc_en, 0);
        check({tag, "_fc_addr"}, fc_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out"}, out_cls, 0);
        check({tag, "_score"}, score, 0);
    endtask

    task automatic fill_img(input int v);
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                img[r][c] = 8'(v);
    endtask

    task automatic fill_kernel(input int v);
        for (int t = 0; t < K*K; t++) ktap[t] = v;
    endtask

    task automatic pack_kernel();
        for (int t = 0; t < K*K; t++) kernel[t*8 +: 8] = 8'(ktap[t]);
    endtask

    task automatic fill_rom(input int v);
        for (int a = 0; a < NROM; a++) rom[a] = 8'(v);
    endtask

    task automatic set_class(input int cl, input int v);
        for (int i = 0; i < N2; i++) rom[cl*N2 + i] = 8'(v);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                img[r][c] = 8'((r*5 + c*3) % 256);
        for (int t = 0; t < K*K; t++) ktap[t] = (t % 7) - 3;
        for (int a = 0; a < NROM; a++) rom[a] = 8'(((a*13) % 11) - 5);
    endtask

    // Reference conv/ReLU/saturating FC/argmax from the image arrays.
    task automatic model(output int cls, output longint best);
        longint feat [N2];
        longint s;
        longint acc;
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++) begin
                s = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s += longint'(ktap[i*K + j]) * longint'(img[r+i][c+j]);
                feat[r*FMAP + c] = (s < 0) ? 0 : s;
            end
        cls = 0;
        best = 0;
        for (int cl = 0; cl < NCLASS; cl++) begin
            acc = 0;
            for (int i = 0; i < N2; i++) begin
                acc = acc + longint'(rom[cl*N2 + i]) * feat[i];
                if (acc > SMAX) acc = SMAX;
                if (acc < SMIN) acc = SMIN;
            end
            if (cl == 0 || acc > best) begin
                best = acc;
                cls = cl;
            end
        end
    endtask

    task automatic run_image(input string name, input int ecls, input longint escore,
                             input bit abort);
        bit ok;
        int tries;
        pack_kernel();
        addr_bad = 0;
        exp_addr = 0;
        if (!abort) sb.push_back('{name, ecls, escore});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < FMAP; r++) begin
            for (int c = 0; c < FMAP; c++) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        in_win[(i*K + j)*8 +: 8] = img[r+i][c+j];
                in_valid = 1'b1;
                start = (r == 3 && c == 5);
                tries = 0;
                ok = 1'b0;
                while (!ok) begin
                    ok = in_ready;
                    @(negedge clk);
                    start = 1'b0;
                    tries++;
                    if (!ok && tries > 20) begin
                        $display("FAIL %s_in_ready_timeout: got no IN_READY required IN_READY", name);
                        $fatal(1, "window handshake stalled");
                    end
                end
            end
        end
        in_valid = 1'b0;
        if (abort) begin
            tries = 0;
            while (!fc_en && tries < LAT) begin
                @(negedge clk);
                tries++;
            end
            check({name, "_fc_started"}, fc_en, 1);
            repeat (100) @(negedge clk);
            rst = 1'b1;
            #1;
            check_reset_outputs({name, "_midfc_rst"});
            @(negedge clk);
            rst = 1'b0;
            $display("txn %s: reset asserted mid-FC", name);
            return;
        end
        ok = 1'b0;
        for (int t = 0; t < LAT + 50; t++) begin
            @(negedge clk);
            start = (t == 40);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no DONE required DONE", name);
            return;
        end
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_out_held"}, out_cls, ecls);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mcls;
        longint mscore;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_win = '0;
        kernel = '0;
        fill_rom(0);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // All-zero image: every score 0, tie keeps class 0.
        fill_img(0);
        fill_kernel(5);
        fill_pattern_rom_only: for (int a = 0; a < NROM; a++) rom[a] = 8'(((a*7) % 9) - 4);
        fill_img(0);
        run_image("zero_img", 0, 0, 1'b0);

        // Features 25, class 7 weights +1.
        fill_img(1);
        fill_kernel(1);
        fill_rom(0);
        set_class(7, 1);
        run_image("class7", 7, 14400, 1'b0);

        // Kernel -1: ReLU zeroes everything.
        fill_kernel(-1);
        fill_rom(0);
        set_class(3, 1);
        run_image("relu_zero", 0, 0, 1'b0);

        // Saturation at 2^31-1 on class 2.
        fill_img(255);
        fill_kernel(127);
        fill_rom(0);
        set_class(2, 127);
        run_image("saturate", 2, SMAX, 1'b0);

        // Reset mid-FC, then the same patterned image in full.
        fill_pattern();
        run_image("abort", 0, 0, 1'b1);
        model(mcls, mscore);
        run_image("pattern", mcls, mscore, 1'b0);

        // Tie between classes 1 and 6 keeps class 1.
        fill_img(1);
        fill_kernel(0);
        ktap[0] = 3;
        fill_rom(0);
        set_class(0, -1);
        set_class(1, 1);
        set_class(4, -2);
        set_class(6, 1);
        run_image("tie", 1, 1728, 1'b0);

        // All scores negative and equal: class 0 seeds the best.
        fill_rom(-1);
        run_image("all_negative", 0, -1728, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
